// File: rtl/key_conditioner.sv
// key_conditioner: per-channel synchroniser, debouncer, edge pulses and
// hold-to-repeat generator for raw push-button inputs.
module key_conditioner #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_KEYS-1:0] i_key,
    output logic [NUM_KEYS-1:0] o_level,
    output logic [NUM_KEYS-1:0] o_press,
    output logic [NUM_KEYS-1:0] o_release,
    output logic [NUM_KEYS-1:0] o_repeat,
    output logic                o_any_press
);

    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HC_W   = $clog2(HR_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REPEAT_CYCLES - 1);

    localparam logic [NUM_KEYS-1:0] IDLE_RAW = {NUM_KEYS{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] sample;

    logic [DB_W-1:0]     db_cnt      [NUM_KEYS];
    logic [DB_W-1:0]     db_cnt_next [NUM_KEYS];
    logic [NUM_KEYS-1:0] level_q;
    logic [NUM_KEYS-1:0] level_next;
    logic [NUM_KEYS-1:0] press_q;
    logic [NUM_KEYS-1:0] press_next;
    logic [NUM_KEYS-1:0] rel_q;
    logic [NUM_KEYS-1:0] rel_next;

    state_t              state      [NUM_KEYS];
    state_t              state_next [NUM_KEYS];
    logic [HC_W-1:0]     hold_cnt      [NUM_KEYS];
    logic [HC_W-1:0]     hold_cnt_next [NUM_KEYS];
    logic [NUM_KEYS-1:0] rep_q;
    logic [NUM_KEYS-1:0] rep_next;

    // Two-flop synchroniser, parked at the idle raw level during reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= IDLE_RAW;
            sync2 <= IDLE_RAW;
        end else begin
            sync1 <= i_key;
            sync2 <= sync1;
        end
    end

    // Normalise so that 1 always means pressed.
    assign sample = sync2 ^ IDLE_RAW;

    // Debounce decision and edge detection for every channel.
    always_comb begin
        level_next = level_q;
        press_next = '0;
        rel_next   = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            db_cnt_next[i] = '0;
            if (sample[i] != level_q[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    level_next[i] = sample[i];
                    press_next[i] = sample[i];
                    rel_next[i]   = ~sample[i];
                end else begin
                    db_cnt_next[i] = db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounce counters, accepted levels and registered edge pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                db_cnt[i] <= '0;
            end
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                db_cnt[i] <= db_cnt_next[i];
            end
            level_q <= level_next;
            press_q <= press_next;
            rel_q   <= rel_next;
        end
    end

    // Repeat FSM next state; it follows the level being registered this edge,
    // so o_repeat can never coincide with a low o_level (release cycle included).
    always_comb begin
        rep_next = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            state_next[i]    = state[i];
            hold_cnt_next[i] = hold_cnt[i];
            if (!level_next[i]) begin
                state_next[i]    = ST_IDLE;
                hold_cnt_next[i] = '0;
            end else begin
                case (state[i])
                    ST_IDLE: begin
                        if (press_next[i]) begin
                            state_next[i]    = ST_HOLD;
                            hold_cnt_next[i] = '0;
                        end
                    end
                    ST_HOLD: begin
                        if (hold_cnt[i] == HOLD_LAST) begin
                            rep_next[i]      = 1'b1;
                            state_next[i]    = ST_REPEAT;
                            hold_cnt_next[i] = '0;
                        end else begin
                            hold_cnt_next[i] = hold_cnt[i] + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (hold_cnt[i] == REP_LAST) begin
                            rep_next[i]      = 1'b1;
                            hold_cnt_next[i] = '0;
                        end else begin
                            hold_cnt_next[i] = hold_cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_next[i]    = ST_IDLE;
                        hold_cnt_next[i] = '0;
                    end
                endcase
            end
        end
    end

    // Repeat FSM state, hold counters and registered repeat pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                state[i]    <= ST_IDLE;
                hold_cnt[i] <= '0;
            end
            rep_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                state[i]    <= state_next[i];
                hold_cnt[i] <= hold_cnt_next[i];
            end
            rep_q <= rep_next;
        end
    end

    assign o_level     = level_q;
    assign o_press     = press_q;
    assign o_release   = rel_q;
    assign o_repeat    = rep_q;
    assign o_any_press = |press_q;

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Multi-channel push-button front end that sits directly upstream of the Lab1 `Top` random-number core. It synchronises raw board key inputs, debounces them, and emits clean levels plus single-cycle press, release and hold-to-repeat pulses. Those outputs drive `Top`'s `i_start`, `i_control` and index inputs, so one physical press produces exactly one start pulse regardless of contact bounce.

## Interface
- `NUM_KEYS`, default 4: number of independent key channels.
- `ACTIVE_LOW`, default 1: 1 means the raw key reads 0 when pressed (board KEYs); 0 means it reads 1 when pressed.
- `DEBOUNCE_CYCLES`, default 500000: consecutive cycles a new level must persist before it is accepted. Must be ≥1.
- `HOLD_CYCLES`, default 25000000: cycles from the press pulse to the first repeat pulse. Must be ≥1.
- `REPEAT_CYCLES`, default 5000000: cycles between subsequent repeat pulses. Must be ≥1.
- `i_clk`, input, 1: single system clock; all state is on its rising edge.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_key`, input, NUM_KEYS: raw asynchronous key inputs.
- `o_level`, output, NUM_KEYS: debounced pressed state, 1 = pressed, independent of ACTIVE_LOW.
- `o_press`, output, NUM_KEYS: one-cycle pulse when `o_level` rises.
- `o_release`, output, NUM_KEYS: one-cycle pulse when `o_level` falls.
- `o_repeat`, output, NUM_KEYS: hold-to-repeat pulses.
- `o_any_press`, output, 1: OR of `o_press`.

## Operation
- **Synchroniser**
  - Per channel, two flops in series.
  - Reset value is the inactive raw level (1 if ACTIVE_LOW, else 0), so an idle key never yields a post-reset press.
  - Normalised sample = `sync2 ^ ACTIVE_LOW`, so 1 means pressed.
- **Debouncer**
  - Per channel: a counter of width `$clog2(DEBOUNCE_CYCLES)` (minimum 1) and the `o_level` register.
  - Sample equals `o_level`: counter cleared to 0.
  - Sample differs and counter == DEBOUNCE_CYCLES-1: `o_level` toggles and counter clears.
  - Sample differs otherwise: counter increments.
  - Any disagreement shorter than DEBOUNCE_CYCLES restarts the count; glitches are invisible at the outputs.
- **Edge pulses**
  - Registered. `o_press` is high exactly in the first cycle `o_level` reads 1.
  - `o_release` is high exactly in the first cycle `o_level` reads 0 after being 1.
  - Press and release on one channel can never coincide.
- **Repeat FSM**
  - Per channel, three states: IDLE, HOLD, REPEAT. Hold counter width is `$clog2(max(HOLD_CYCLES, REPEAT_CYCLES)+1)`.
  - IDLE → HOLD on press. Counter starts at 0 in the press cycle P.
  - In HOLD, `o_repeat` pulses in cycle P+HOLD_CYCLES, then the FSM enters REPEAT with the counter cleared.
  - In REPEAT, `o_repeat` pulses every REPEAT_CYCLES cycles: P+HOLD_CYCLES+k·REPEAT_CYCLES for k ≥ 1.
  - `o_level` = 0 in any state forces IDLE and clears the counter.
  - `o_repeat` is never high in a cycle where `o_level` is 0, including the `o_release` cycle.
- **Channel independence**: channels share nothing except the clock, reset and the `o_any_press` OR. Simultaneous events on several channels pulse in the same cycle.
- **Reset (asynchronous, may occur mid-operation)**
  - All outputs, counters and FSMs go immediately to 0/IDLE.
  - Synchronisers go to the inactive level.
  - A key still held through reset is re-detected as a fresh press after normal latency.

## Timing
- Edge 0 is the first rising edge that captures a new raw value into sync stage 1 (raw held stable afterwards).
- `o_level` changes at edge DEBOUNCE_CYCLES+1.
- `o_press`/`o_release` are high for the one cycle following that edge.
- Press and release latency are identical, so the debounced pulse width equals the raw pulse width when the raw pulse is ≥ DEBOUNCE_CYCLES.
- Reset values: `o_level`, `o_press`, `o_release`, `o_repeat`, `o_any_press` all 0.
- No combinational path from `i_key` to any output.

## Test plan
Bench parameters: NUM_KEYS=4, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.

1. **Reset.** Pulse `i_rst_n` low with `i_key`=4'hF → all outputs 0 during and after reset; no pulses for 50 cycles.
2. **Clean press and release.** Drive `i_key[0]` low for 30 cycles → `o_level[0]` rises at edge 5; one `o_press[0]`/`o_any_press` cycle. After release, one `o_release[0]` with the same latency.
3. **Repeat.** Same 30-cycle hold as scenario 2 → `o_repeat[0]` pulses at P+10, 13, 16, 19, 22, 25, 28 (7 pulses) and none after release.
4. **Bounce.** Toggle `i_key[1]` low for 3 cycles, high for 1, low for 2, then high → no activity on any output. A final low hold of 4+ cycles gives exactly one press.
5. **Simultaneous keys.** Drop `i_key[2]` and `i_key[3]` on the same edge → both `o_press` bits high in the same single cycle; `o_any_press` high for one cycle.
6. **Reset mid-hold.** Assert reset during REPEAT on key 0 with the key still held → outputs clear immediately. After reset deasserts, `o_press[0]` fires at edge 5 of re-sampling, and repeats restart from HOLD.
